constraint_sampler_ctrl: RTL and testbench
==========================================

# constraint_sampler_ctrl

Sequential controller that drives a combinational constraint-checker block (flat input vector in, single `sat` bit out) to produce constrained-random samples. Generates candidates with an internal Galois LFSR, presents each to the checker, and retains candidates for which `sat` is high. Emits each accepted candidate on a valid/ready output stream and gives up after a bounded number of rejections. Sits between the sampler testbench/host and the checker.

## Interface
Parameters:
- `W`, 32: candidate width. This is the concatenated checker input width.
- `TAPS`, 32'h8020_0003: Galois feedback mask, W bits. Must be maximal-length for W.
- `SEED`, 32'h0000_0001: reset and replacement seed, W bits. Must be nonzero.
- `MAX_TRIES`, 1024: rejections allowed per sample before failing. Must be ≥1.
- `CW`, 16: width of the request and try counters.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `seed_load` in 1: loads `seed` into the LFSR. Honoured in IDLE or FAIL only.
- `seed` in W: seed value. Zero is replaced by `SEED`.
- `start` in 1: begin a request of `n_req` samples. Honoured in IDLE or FAIL only.
- `n_req` in CW: number of samples requested. Zero means the request completes immediately with no samples.
- `cand` out W: current candidate, registered, fed to the checker.
- `sat` in 1: checker verdict, combinational from `cand`.
- `sample_valid` out 1, `sample_ready` in 1, `sample_data` out W: accepted-sample stream.
- `busy` out 1: high in SEARCH and HOLD.
- `done` out 1: one-cycle pulse when a request completes.
- `fail` out 1: sticky. Set when MAX_TRIES rejections occur for a single sample.
- `tries` out CW: rejections counted for the current sample.

## Operation
- FSM states: IDLE, SEARCH, HOLD, FAIL.
- IDLE:
  - `seed_load` sets `cand`←(`seed`==0 ? `SEED` : `seed`).
  - `start` with `n_req`==0 pulses `done` and stays in IDLE.
  - `start` with `n_req`>0 latches the remaining count = `n_req`, clears `tries`, and enters SEARCH.
  - If `seed_load` and `start` arrive together, the seed load takes effect first; the new seed is the first candidate.
- SEARCH, evaluated once per cycle against the current `cand`:
  - accept = `sat` (further qualified under Configuration).
  - On accept: `sample_data`←`cand`, `sample_valid`←1, go to HOLD.
  - On reject with `tries`==MAX_TRIES−1: `tries`←MAX_TRIES, `fail`←1, go to FAIL. `cand` is not stepped.
  - On any other reject: `tries`++, `cand`←lfsr_step(`cand`).
- HOLD: `sample_valid` stays high and `sample_data` stays stable until `sample_ready`. On the handshake cycle:
  - `sample_valid`←0.
  - `cand`←lfsr_step(`cand`).
  - `tries`←0.
  - remaining−1.
  - If the remaining count reaches 0: pulse `done` and go to IDLE. Otherwise go to SEARCH.
- FAIL: `fail` stays high.
  - `start` clears `fail`, resumes from the current `cand`, and re-arms with the new `n_req`.
  - `seed_load` is honoured.
- lfsr_step(s): `(s>>1) ^ (s[0] ? TAPS : 0)`. A nonzero state never becomes zero.
- `start` and `seed_load` are ignored while `busy`.
- Counters saturate and never wrap. MAX_TRIES must fit in CW.
- Reset values:
  - `cand`=`SEED`.
  - `sample_data`=0.
  - `sample_valid`, `busy`, `done`, `fail` = 0.
  - `tries`=0.
  - state=IDLE.
- Asynchronous reset mid-request aborts the request. Any in-flight sample is dropped and no `done` is produced.

## Timing
- `start` sampled at cycle t → `busy`=1 at t+1, first candidate evaluated at t+1.
- `sat` is sampled in the same cycle `cand` is presented. The checker path must close in one cycle.
- Accept at cycle t → `sample_valid`=1 at t+1.
- Handshake at t → next candidate evaluated at t+1.
- Maximum throughput with `sat`=1 and `sample_ready`=1: one sample every 2 cycles.
- `done` asserts in the cycle after the final handshake, for exactly 1 cycle, with `busy`=0 in that same cycle.
- `fail` rises the cycle after the MAX_TRIES-th rejection.

## Configuration
- `SAMPLER_DEDUP_EN` defined:
  - Holds a register `last` (reset 0) with a `last_vld` flag (reset 0, cleared by `start`).
  - accept = `sat` && !(`last_vld` && `cand`==`last`). A suppressed duplicate counts as a rejection.
  - `last`←`cand` on every accept.
- `SAMPLER_DEDUP_EN` undefined: accept = `sat`. No `last` register is built.

## Test plan
All scenarios use W=8, TAPS=8'hB8, SEED=8'h01 unless stated.
- Reset, then idle 5 cycles → `cand`=8'h01, all status outputs 0, `tries`=0.
- `sat` tied 1, `sample_ready`=1, `start` with `n_req`=4 → 4 samples on cycles t+2, t+4, t+6, t+8, with data 01,B8,5C,2E; `done` pulses 1 cycle at t+9.
- `sat` tied 0, MAX_TRIES=16, `start` with `n_req`=1 → `fail`=1 after 16 SEARCH cycles, `tries`=16, `sample_valid` never asserts. A second `start` clears `fail`.
- `seed_load` with `seed`=0 then `start` → first `cand`=8'h01. `seed_load` with 8'h5A → first `cand`=8'h5A. `seed_load` while busy → ignored.
- `sat` tied 1, `sample_ready` held low 10 cycles → `sample_valid` held high and `sample_data` stable throughout; `cand` not stepped.
- `sat`=(`cand`==8'h01), `n_req`=2, MAX_TRIES=300:
  - Without dedup: second sample = 01 after 254 rejections (`tries`=254).
  - With `SAMPLER_DEDUP_EN`: `fail`=1 with `tries`=300.

Source files
------------

// File: rtl/constraint_sampler_ctrl_if.sv
// constraint_sampler_ctrl_if: valid/ready stream carrying accepted constrained-random samples.
interface constraint_sampler_ctrl_if #(parameter int W = 32);
    logic         sample_valid;
    logic         sample_ready;
    logic [W-1:0] sample_data;
    modport master(output sample_valid, output sample_data, input sample_ready);
    modport slave(input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/constraint_sampler_ctrl.sv
// constraint_sampler_ctrl: LFSR candidate generator driving a combinational constraint checker.
// Optional SAMPLER_DEDUP_EN suppresses a candidate equal to the previously accepted one.
module constraint_sampler_ctrl #(
    parameter int           W         = 32,
    parameter logic [W-1:0] TAPS      = W'(32'h8020_0003),
    parameter logic [W-1:0] SEED      = W'(32'h0000_0001),
    parameter int           MAX_TRIES = 1024,
    parameter int           CW        = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_seed_load,
    input  logic [W-1:0]                      i_seed,
    input  logic                              i_start,
    input  logic [CW-1:0]                     i_n_req,
    output logic [W-1:0]                      o_cand,
    input  logic                              i_sat,
    constraint_sampler_ctrl_if.master         o_smp,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_fail,
    output logic [CW-1:0]                     o_tries
);
    localparam logic [1:0] S_IDLE = 2'd0, S_SEARCH = 2'd1, S_HOLD = 2'd2, S_FAIL = 2'd3;
    localparam logic [CW-1:0] MT = CW'(MAX_TRIES);

    logic [1:0]    r_state;
    logic [W-1:0]  r_cand, r_data;
    logic          r_valid, r_done, r_fail;
    logic [CW-1:0] r_tries, r_rem;
    logic          w_armable, w_accept;
    logic [W-1:0]  w_step, w_seed;

    assign w_armable = (r_state == S_IDLE) || (r_state == S_FAIL);
    assign w_step    = (r_cand >> 1) ^ (r_cand[0] ? TAPS : '0);
    assign w_seed    = (i_seed == '0) ? SEED : i_seed;

`ifdef SAMPLER_DEDUP_EN
    logic [W-1:0] r_last;
    logic         r_last_vld;
    assign w_accept = i_sat && !(r_last_vld && r_cand == r_last);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else if (w_armable && i_start) begin
            r_last_vld <= 1'b0;
        end else if (r_state == S_SEARCH && w_accept) begin
            r_last     <= r_cand;
            r_last_vld <= 1'b1;
        end
    end
`else
    assign w_accept = i_sat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cand  <= SEED;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            r_tries <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_FAIL: begin
                    // a simultaneous seed load lands first so the new seed is the first candidate
                    if (i_seed_load) r_cand <= w_seed;
                    if (i_start) begin
                        r_fail  <= 1'b0;
                        r_tries <= '0;
                        r_rem   <= i_n_req;
                        r_done  <= (i_n_req == '0);
                        r_state <= (i_n_req == '0) ? S_IDLE : S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_accept) begin
                        r_data  <= r_cand;
                        r_valid <= 1'b1;
                        r_state <= S_HOLD;
                    end else if (r_tries >= MT - 1'b1) begin
                        r_tries <= MT;
                        r_fail  <= 1'b1;
                        r_state <= S_FAIL;
                    end else begin
                        r_tries <= r_tries + 1'b1;
                        r_cand  <= w_step;
                    end
                end
                default: begin
                    if (o_smp.sample_ready) begin
                        r_valid <= 1'b0;
                        r_cand  <= w_step;
                        r_tries <= '0;
                        r_rem   <= (r_rem == '0) ? r_rem : r_rem - 1'b1;
                        r_done  <= (r_rem <= CW'(1));
                        r_state <= (r_rem <= CW'(1)) ? S_IDLE : S_SEARCH;
                    end
                end
            endcase
        end
    end

    assign o_cand             = r_cand;
    assign o_smp.sample_valid = r_valid;
    assign o_smp.sample_data  = r_data;
    assign o_busy             = (r_state == S_SEARCH) || (r_state == S_HOLD);
    assign o_done             = r_done;
    assign o_fail             = r_fail;
    assign o_tries            = r_tries;
endmodule

// File: tb/tb_constraint_sampler_ctrl.sv
// tb_constraint_sampler_ctrl: directed and randomized checks against a request-level reference model.
module tb_constraint_sampler_ctrl;
    localparam int         MT   = 300;
    localparam int         MTF  = 16;
    localparam logic [7:0] TAPS = 8'hB8;
    localparam logic [7:0] SEED = 8'h01;
`ifdef SAMPLER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        seed_load = 1'b0, start = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic [15:0] n_req = 16'h0;
    logic [7:0]  cand, cand_f;
    logic        sat, busy, done, fail, busy_f, done_f, fail_f;
    logic [15:0] tries, tries_f;
    int          mode = 0;
    logic [7:0]  pmask = 8'h00, pval = 8'h00;

    always_comb sat = (mode == 1) ? 1'b1 : (mode == 2) ? (cand == 8'h01) :
                      (mode == 3) ? ((cand & pmask) == pval) : 1'b0;

    constraint_sampler_ctrl_if #(.W(8)) smp();
    constraint_sampler_ctrl_if #(.W(8)) smp_f();

    constraint_sampler_ctrl #(.W(8), .TAPS(TAPS), .SEED(SEED), .MAX_TRIES(MT), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_seed_load(seed_load), .i_seed(seed), .i_start(start),
        .i_n_req(n_req), .o_cand(cand), .i_sat(sat), .o_smp(smp), .o_busy(busy),
        .o_done(done), .o_fail(fail), .o_tries(tries));

    constraint_sampler_ctrl #(.W(8), .TAPS(TAPS), .SEED(SEED), .MAX_TRIES(MTF), .CW(16)) u_f (
        .clk(clk), .rst_n(rst_n), .i_seed_load(seed_load), .i_seed(seed), .i_start(start),
        .i_n_req(n_req), .o_cand(cand_f), .i_sat(1'b0), .o_smp(smp_f), .o_busy(busy_f),
        .o_done(done_f), .o_fail(fail_f), .o_tries(tries_f));

    int         errors = 0, checks = 0;
    logic [7:0] mcand = SEED;
    logic [7:0] exp_q[$];
    bit         exp_fail;
    int         exp_tries, peak;
    logic [7:0] exp_cand;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 8'h00);
    endfunction

    function automatic bit pred(input logic [7:0] c);
        return (mode == 1) ? 1'b1 : (mode == 2) ? (c == 8'h01) :
               (mode == 3) ? ((c & pmask) == pval) : 1'b0;
    endfunction

    // walk the candidate sequence sample by sample, following the acceptance and give-up rules
    task automatic model(input logic [7:0] c0, input int n);
        logic [7:0] c = c0, last = 8'h00;
        bit have_last = 1'b0;
        int t = 0;
        exp_q.delete();
        exp_fail = 1'b0;
        for (int k = 0; k < n && !exp_fail; k++) begin
            t = 0;
            forever begin
                if (pred(c) && !(DEDUP && have_last && c == last)) begin
                    exp_q.push_back(c);
                    last = c;
                    have_last = 1'b1;
                    c = nxt(c);
                    t = 0;
                    break;
                end
                if (t == MT - 1) begin
                    t = MT;
                    exp_fail = 1'b1;
                    break;
                end
                t++;
                c = nxt(c);
            end
        end
        exp_tries = t;
        exp_cand = c;
    endtask

    task automatic run_req(input int n, input bit ld, input logic [7:0] sd, input bit rr, input string tag);
        int got = 0, cyc = 0;
        if (ld) begin
            mcand = (sd == 8'h00) ? SEED : sd;
            seed_load = 1'b1;
            seed = sd;
        end
        model(mcand, n);
        n_req = 16'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        seed_load = 1'b0;
        peak = 0;
        chk({tag, "_first_cand"}, 32'(cand), 32'(mcand));
        while (!done && !fail && cyc < 5000) begin
            if (int'(tries) > peak) peak = int'(tries);
            smp.sample_ready = rr ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (smp.sample_valid && smp.sample_ready) begin
                chk({tag, "_data"}, 32'(smp.sample_data), (got < exp_q.size()) ? 32'(exp_q[got]) : 32'hx);
                got++;
            end
            tick();
            cyc++;
        end
        chk({tag, "_no_timeout"}, 32'(cyc < 5000), 32'd1);
        chk({tag, "_count"}, 32'(got), 32'(exp_q.size()));
        chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        chk({tag, "_tries"}, 32'(tries), 32'(exp_tries));
        chk({tag, "_cand"}, 32'(cand), 32'(exp_cand));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        mcand = exp_cand;
        smp.sample_ready = 1'b1;
    endtask

    task automatic do_reset();
        seed_load = 1'b0;
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        mcand = SEED;
    endtask

    initial begin
        logic [7:0] plan_data[4] = '{8'h01, 8'hB8, 8'h5C, 8'h2E};
        logic [7:0] held, cf;
        smp.sample_ready = 1'b1;
        smp_f.sample_ready = 1'b1;

        // reset state
        do_reset();
        repeat (5) tick();
        chk("rst_cand", 32'(cand), 32'h01);
        chk("rst_valid", 32'(smp.sample_valid), 32'd0);
        chk("rst_data", 32'(smp.sample_data), 32'd0);
        chk("rst_status", {29'd0, busy, done, fail}, 32'd0);
        chk("rst_tries", 32'(tries), 32'd0);

        // back-to-back throughput with sat tied high
        mode = 1;
        n_req = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tp_busy_t1", 32'(busy), 32'd1);
        chk("tp_valid_t1", 32'(smp.sample_valid), 32'd0);
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("tp_valid", 32'(smp.sample_valid), 32'((k % 2 == 0) && k <= 8));
            if (smp.sample_valid) chk("tp_data", 32'(smp.sample_data), 32'(plan_data[k/2-1]));
            chk("tp_done", 32'(done), 32'(k == 9));
            if (k == 9) chk("tp_busy_done", 32'(busy), 32'd0);
        end
        tick();
        chk("tp_done_pulse", 32'(done), 32'd0);
        model(SEED, 4);
        mcand = exp_cand;

        // give-up after MAX_TRIES rejections (16-try instance)
        do_reset();
        mode = 0;
        n_req = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            tick();
            chk("mt_valid", 32'(smp_f.sample_valid), 32'd0);
        end
        chk("mt_fail_early", 32'(fail_f), 32'd0);
        tick();
        cf = SEED;
        for (int k = 0; k < MTF - 1; k++) cf = nxt(cf);
        chk("mt_fail", 32'(fail_f), 32'd1);
        chk("mt_tries", 32'(tries_f), 32'(MTF));
        chk("mt_busy", 32'(busy_f), 32'd0);
        chk("mt_cand", 32'(cand_f), 32'(cf));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mt_fail_clr", 32'(fail_f), 32'd0);
        chk("mt_rearm", {busy_f, tries_f}, {15'd0, 1'b1, 16'd0});

        // seed handling
        do_reset();
        mode = 1;
        run_req(1, 1'b1, 8'h00, 1'b0, "seed0");
        run_req(1, 1'b1, 8'h5A, 1'b0, "seed5a");

        // back-pressure: output held, candidate frozen, start/seed_load ignored while busy
        smp.sample_ready = 1'b0;
        n_req = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        held = mcand;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(smp.sample_valid), 32'd1);
            chk("bp_data", 32'(smp.sample_data), 32'(held));
            chk("bp_cand", 32'(cand), 32'(held));
            seed_load = (k == 4);
            start = (k == 4);
            seed = 8'h33;
            tick();
        end
        seed_load = 1'b0;
        start = 1'b0;
        chk("bp_busy", 32'(busy), 32'd1);
        smp.sample_ready = 1'b1;
        tick();
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_step", 32'(cand), 32'(nxt(held)));
        mcand = nxt(held);

        // single-value constraint revisits the seed after a full LFSR period
        do_reset();
        mode = 2;
        run_req(2, 1'b0, 8'h00, 1'b0, "single");
`ifdef SAMPLER_DEDUP_EN
        chk("dedup_fail", 32'(fail), 32'd1);
        chk("dedup_tries", 32'(tries), 32'd300);
`else
        chk("nodedup_peak", 32'(peak), 32'd254);
`endif

        // randomized requests
        do_reset();
        for (int it = 0; it < 24; it++) begin
            mode = ($urandom_range(0, 7) == 0) ? 0 : ($urandom_range(0, 3) == 0) ? 1 : 3;
            pmask = 8'($urandom_range(0, 255)) & 8'h1D;
            pval = 8'($urandom_range(0, 255)) & pmask;
            run_req(int'($urandom_range(0, 4)), $urandom_range(0, 1) == 1,
                    8'($urandom_range(0, 255)), 1'b1, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
